// File: rtl/prog_seq_pkg.sv
// Shared types and program table for the program sequencer.
package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RST,
    RUN,
    SETTLE,
    CHECK,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic [63:0] start_pc;
    logic [63:0] end_pc;
    logic [63:0] expect_val;
  } prog_rec_t;

  localparam prog_rec_t PROG_0 = '{start_pc: 64'h0, end_pc: 64'h34, expect_val: 64'hF};
  localparam prog_rec_t PROG_1 = '{start_pc: 64'h34, end_pc: 64'h58,
                                   expect_val: 64'h1234_5678_9ABC_DEF0};

  // Unpopulated indices read back as all-zero records.
  function automatic prog_rec_t prog_lookup(input logic [3:0] idx);
    prog_rec_t rec;
    rec = '0;
    case (idx)
      4'd0:    rec = PROG_0;
      4'd1:    rec = PROG_1;
      default: rec = '0;
    endcase
    return rec;
  endfunction

endpackage

// File: rtl/prog_table.sv
// Combinational index-to-record lookup into the program table.
module prog_table
  import prog_seq_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [63:0] start_pc,
  output logic [63:0] end_pc,
  output logic [63:0] expect_val
);

  prog_rec_t rec;

  always_comb begin
    rec        = prog_lookup(idx);
    start_pc   = rec.start_pc;
    end_pc     = rec.end_pc;
    expect_val = rec.expect_val;
  end

endmodule

// File: rtl/prog_sequencer.sv
// Runs each table program on the core: reset with start PC, run to end PC,
// settle one cycle, compare the data-memory result and tally pass/fail.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int NUM_PROGS    = 2,
  parameter int RESET_CYCLES = 1,
  parameter int WATCHDOG_MAX = 255
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        go,
  input  logic [63:0] currentpc,
  input  logic [63:0] dmemout,
  output logic        cpu_resetl,
  output logic [63:0] startpc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_count,
  output logic [15:0] fail_mask,
  output logic        timeout,
  output logic [3:0]  prog_idx
);

  localparam int CYC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int WD_W  = $clog2(WATCHDOG_MAX + 1);

  state_t            state_reg, state_next;
  logic [CYC_W-1:0]  cyc_cnt_reg, cyc_cnt_next;
  logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic              cpu_resetl_reg, cpu_resetl_next;
  logic [63:0]       startpc_reg, startpc_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [7:0]        pass_count_reg, pass_count_next;
  logic [15:0]       fail_mask_reg, fail_mask_next;
  logic              timeout_reg, timeout_next;
  logic [3:0]        prog_idx_reg, prog_idx_next;

  logic [3:0]        tbl_idx;
  logic [63:0]       tbl_start, tbl_end, tbl_expect;

  // The table is read at the program about to be loaded while idle/advancing,
  // otherwise at the program currently running; this keeps it register-driven.
  always_comb begin
    tbl_idx = prog_idx_reg;
    if (state_reg == NEXT)
      tbl_idx = prog_idx_reg + 4'd1;
    else if (state_reg == IDLE || state_reg == DONE)
      tbl_idx = 4'd0;
  end

  prog_table u_table (
    .idx       (tbl_idx),
    .start_pc  (tbl_start),
    .end_pc    (tbl_end),
    .expect_val(tbl_expect)
  );

  always_comb begin
    state_next      = state_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    wd_cnt_next     = wd_cnt_reg;
    cpu_resetl_next = cpu_resetl_reg;
    startpc_next    = startpc_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    pass_count_next = pass_count_reg;
    fail_mask_next  = fail_mask_reg;
    timeout_next    = timeout_reg;
    prog_idx_next   = prog_idx_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (go) begin
          state_next      = CPU_RST;
          pass_count_next = 8'd0;
          fail_mask_next  = 16'd0;
          timeout_next    = 1'b0;
          prog_idx_next   = 4'd0;
          busy_next       = 1'b1;
          done_next       = 1'b0;
          cpu_resetl_next = 1'b0;
          cyc_cnt_next    = '0;
          wd_cnt_next     = '0;
          startpc_next    = tbl_start;
        end
      end
      CPU_RST: begin
        cpu_resetl_next = 1'b0;
        startpc_next    = tbl_start;
        if (cyc_cnt_reg == CYC_W'(RESET_CYCLES - 1)) begin
          state_next      = RUN;
          cpu_resetl_next = 1'b1;
          wd_cnt_next     = '0;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        // Reaching the end address wins over a simultaneous watchdog expiry.
        if (currentpc >= tbl_end) begin
          state_next = SETTLE;
        end else if (wd_cnt_reg == WD_W'(WATCHDOG_MAX)) begin
          timeout_next    = 1'b1;
          fail_mask_next  = fail_mask_reg | (16'h1 << prog_idx_reg);
          cpu_resetl_next = 1'b0;
          state_next      = NEXT;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      SETTLE: state_next = CHECK;
      CHECK: begin
        if (dmemout == tbl_expect) begin
          if (pass_count_reg != 8'hFF)
            pass_count_next = pass_count_reg + 8'd1;
        end else begin
          fail_mask_next = fail_mask_reg | (16'h1 << prog_idx_reg);
        end
        cpu_resetl_next = 1'b0;
        state_next      = NEXT;
      end
      NEXT: begin
        cpu_resetl_next = 1'b0;
        if (prog_idx_reg == 4'(NUM_PROGS - 1)) begin
          state_next = DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else begin
          prog_idx_next = prog_idx_reg + 4'd1;
          cyc_cnt_next  = '0;
          wd_cnt_next   = '0;
          startpc_next  = tbl_start;
          state_next    = CPU_RST;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_reg      <= IDLE;
      cyc_cnt_reg    <= '0;
      wd_cnt_reg     <= '0;
      cpu_resetl_reg <= 1'b0;
      startpc_reg    <= 64'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pass_count_reg <= 8'd0;
      fail_mask_reg  <= 16'd0;
      timeout_reg    <= 1'b0;
      prog_idx_reg   <= 4'd0;
    end else begin
      state_reg      <= state_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      wd_cnt_reg     <= wd_cnt_next;
      cpu_resetl_reg <= cpu_resetl_next;
      startpc_reg    <= startpc_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      pass_count_reg <= pass_count_next;
      fail_mask_reg  <= fail_mask_next;
      timeout_reg    <= timeout_next;
      prog_idx_reg   <= prog_idx_next;
    end
  end

  assign cpu_resetl = cpu_resetl_reg;
  assign startpc    = startpc_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign pass_count = pass_count_reg;
  assign fail_mask  = fail_mask_reg;
  assign timeout    = timeout_reg;
  assign prog_idx   = prog_idx_reg;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer with a behavioural core model.
module tb_prog_sequencer;

  localparam int NP = 2;
  localparam int RC = 1;
  localparam int WD = 255;
  localparam int M_NORMAL = 0;
  localparam int M_STUCK  = 1;
  localparam int M_LATE   = 2;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        go;
  logic [63:0] currentpc;
  logic [63:0] dmemout;
  logic        cpu_resetl;
  logic [63:0] startpc;
  logic        busy;
  logic        done;
  logic [7:0]  pass_count;
  logic [15:0] fail_mask;
  logic        timeout;
  logic [3:0]  prog_idx;

  always #5 CLK = ~CLK;

  prog_sequencer #(.NUM_PROGS(NP), .RESET_CYCLES(RC), .WATCHDOG_MAX(WD)) dut (
    .CLK(CLK), .resetl(resetl), .go(go), .currentpc(currentpc), .dmemout(dmemout),
    .cpu_resetl(cpu_resetl), .startpc(startpc), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_mask(fail_mask), .timeout(timeout), .prog_idx(prog_idx)
  );

  logic [63:0] t_start [2] = '{64'h0, 64'h34};
  logic [63:0] t_end   [2] = '{64'h34, 64'h58};
  logic [63:0] t_exp   [2] = '{64'hF, 64'h1234_5678_9ABC_DEF0};

  int          mode [2];
  int unsigned jump [2];
  logic [63:0] dval [2];

  typedef struct {
    int unsigned pass_n;
    logic [15:0] fail;
    logic        to;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq_n = 0;

  // Core model: PC is loaded with startpc in reset, then follows the scripted mode.
  int unsigned rc;
  int          cp;
  always @(posedge CLK) begin
    if (!cpu_resetl) rc <= 0;
    else             rc <= rc + 1;
  end

  always_comb begin
    cp = (startpc == t_start[1]) ? 1 : 0;
    case (mode[cp])
      M_NORMAL: currentpc = startpc + 64'(rc) * 64'd4;
      M_STUCK:  currentpc = 64'h10;
      default:  currentpc = (rc >= jump[cp]) ? t_end[cp] : startpc;
    endcase
    dmemout = dval[cp];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected sequence outcome from the scripted core behaviour.
  function automatic exp_t model();
    exp_t        e;
    logic [63:0] k;
    bit          reached;
    e.pass_n = 0; e.fail = 16'd0; e.to = 1'b0; e.cyc = 0;
    for (int p = 0; p < NP; p++) begin
      k = 64'd0;
      reached = 1'b0;
      case (mode[p])
        M_NORMAL: begin k = (t_end[p] - t_start[p] + 64'd3) / 64'd4; reached = (k <= 64'(WD)); end
        M_STUCK:  begin k = 64'd0; reached = (64'h10 >= t_end[p]); end
        default:  begin k = 64'(jump[p]); reached = (k <= 64'(WD)); end
      endcase
      if (reached) begin
        e.cyc += RC + int'(k) + 1 + 3;
        if (dval[p] == t_exp[p]) e.pass_n++;
        else e.fail[p] = 1'b1;
      end else begin
        e.cyc += RC + WD + 1 + 1;
        e.fail[p] = 1'b1;
        e.to = 1'b1;
      end
    end
    return e;
  endfunction

  // Monitor: one scoreboard pop per completed sequence.
  int busy_cnt = 0;
  bit done_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          $display("seq %0d: pass=%0d fail_mask=%0h timeout=%0d busy_cycles=%0d",
                   seq_n, pass_count, fail_mask, timeout, busy_cnt);
          chk("pass_count", pass_count, e.pass_n);
          chk("fail_mask", fail_mask, e.fail);
          chk("timeout", timeout, e.to);
          chk("busy_cycles", busy_cnt, e.cyc);
          chk("prog_idx_last", prog_idx, NP - 1);
          chk("busy_at_done", busy, 0);
        end
        seq_n++;
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end else if (!done) begin
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic set_prog(input int p, input int md, input int unsigned jp, input logic [63:0] dv);
    mode[p] = md; jump[p] = jp; dval[p] = dv;
  endtask

  task automatic run_seq(input bit measure, input bit abort_p1);
    exp_t e;
    int   n;
    e = model();
    exp_q.push_back(e);
    @(negedge CLK); go = 1'b1;
    @(negedge CLK); go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_done_clr", done, 0);
    chk("go_pass_clr", pass_count, 0);
    chk("go_fail_clr", fail_mask, 0);
    chk("go_timeout_clr", timeout, 0);
    if (measure) begin
      chk("startpc_p0", startpc, t_start[0]);
      n = 0;
      while (!cpu_resetl && n < 50) begin n++; @(negedge CLK); end
      chk("rst_low_p0", n, RC);
      // go while running must be ignored
      go = 1'b1;
      @(negedge CLK); go = 1'b0;
      chk("busy_after_go", busy, 1);
      n = 0;
      while (!(busy && !cpu_resetl && startpc == t_start[1]) && n < 500) begin n++; @(negedge CLK); end
      n = 0;
      while (!cpu_resetl && startpc == t_start[1] && n < 50) begin n++; @(negedge CLK); end
      chk("rst_low_p1", n, RC);
      chk("startpc_hold_p1", startpc, t_start[1]);
    end
    if (abort_p1) begin
      n = 0;
      while (!(startpc == t_start[1] && cpu_resetl) && n < 1000) begin n++; @(negedge CLK); end
      repeat (3) @(negedge CLK);
      chk("pre_abort_pass", pass_count, 1);
      #2 resetl = 1'b0;
      #1;
      chk("abort_cpu_resetl", cpu_resetl, 0);
      chk("abort_startpc", startpc, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass_count, 0);
      chk("abort_fail", fail_mask, 0);
      chk("abort_timeout", timeout, 0);
      chk("abort_prog_idx", prog_idx, 0);
      exp_q.delete();
      @(negedge CLK); resetl = 1'b1;
      @(negedge CLK);
    end else begin
      n = 0;
      while (!done && n < 3000) begin @(negedge CLK); n++; end
      if (!done) chk("done_wait", done, 1);
      @(negedge CLK);
    end
  endtask

  initial begin
    resetl = 1'b0;
    go = 1'b0;
    for (int p = 0; p < NP; p++) set_prog(p, M_NORMAL, 0, t_exp[p]);
    repeat (3) @(negedge CLK);
    chk("rst_cpu_resetl", cpu_resetl, 0);
    chk("rst_startpc", startpc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_fail", fail_mask, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_prog_idx", prog_idx, 0);
    resetl = 1'b1;
    @(negedge CLK);

    run_seq(1'b1, 1'b0);                                   // both pass
    set_prog(1, M_NORMAL, 0, 64'hDEAD);
    run_seq(1'b0, 1'b0);                                   // program 1 mismatch
    set_prog(0, M_STUCK, 0, t_exp[0]);
    set_prog(1, M_NORMAL, 0, t_exp[1]);
    run_seq(1'b0, 1'b0);                                   // program 0 watchdog
    set_prog(0, M_LATE, WD, t_exp[0]);
    set_prog(1, M_LATE, WD, t_exp[1]);
    run_seq(1'b0, 1'b0);                                   // end hit on watchdog cycle
    set_prog(0, M_LATE, WD + 1, t_exp[0]);
    run_seq(1'b0, 1'b0);                                   // one cycle too late
    set_prog(0, M_NORMAL, 0, t_exp[0]);
    set_prog(1, M_NORMAL, 0, t_exp[1]);
    run_seq(1'b0, 1'b1);                                   // abort in program 1
    run_seq(1'b0, 1'b0);                                   // clean rerun

    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p < NP; p++)
        set_prog(p, int'($urandom_range(0, 2)), $urandom_range(250, 260),
                 ($urandom_range(0, 1) == 1) ? t_exp[p] : {$urandom, $urandom});
      run_seq(1'b0, 1'b0);
    end

    if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Hardware controller that sequences the single-cycle processor through a fixed list of self-checking programs.
- For each program it:
  - holds the core in reset with that program's start PC;
  - releases the core and watches `currentpc` until it reaches the program's end address;
  - waits one extra cycle for the data-memory result;
  - compares `dmemout` against the expected pass code and tallies the outcome.
- Sits between the processor instance and a top-level board or bench harness; it drives the core's `resetl`/`startpc` and observes `currentpc`/`dmemout`.

Parameters:
- NUM_PROGS, 2, number of table entries run per sequence (1..16).
- RESET_CYCLES, 1, cycles `cpu_resetl` is held low before each program.
- WATCHDOG_MAX, 255, RUN-state cycle limit per program before timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- go  in  1  single-cycle start pulse; ignored unless in IDLE or DONE.
- currentpc  in  64  PC from the processor.
- dmemout  in  64  data-memory read output from the processor.
- cpu_resetl  out  1  active-low reset to the processor.
- startpc  out  64  start PC to the processor.
- busy  out  1  high from the cycle after an accepted `go` until DONE.
- done  out  1  high while in DONE.
- pass_count  out  8  number of programs passed in the current or last sequence.
- fail_mask  out  16  bit i set = program i failed, by mismatch or timeout.
- timeout  out  1  sticky; set if any program hit the watchdog.
- prog_idx  out  4  index of the program currently or last run.

Behaviour:
- Async reset (`resetl`=0):
  - state=IDLE;
  - `cpu_resetl`=0, `startpc`=0;
  - `busy`=0, `done`=0;
  - `pass_count`=0, `fail_mask`=0, `timeout`=0, `prog_idx`=0;
  - all counters cleared.
  - Reset mid-sequence aborts immediately; the processor is parked in reset.
- All outputs are registered.
- States: IDLE, CPU_RST, RUN, SETTLE, CHECK, NEXT, DONE.
- IDLE/DONE + `go`=1:
  - clear `pass_count`, `fail_mask`, `timeout`, `prog_idx`;
  - go to CPU_RST.
- CPU_RST:
  - `cpu_resetl`=0;
  - `startpc`=table[`prog_idx`].start;
  - `cyc_cnt` counts RESET_CYCLES cycles, then → RUN with `cpu_resetl`=1 from the next cycle.
- RUN:
  - `wd_cnt` increments each cycle, starting from 0.
  - If `currentpc` >= table.end (unsigned 64-bit compare) → SETTLE.
  - Else if `wd_cnt`==WATCHDOG_MAX → set `timeout`, set `fail_mask`[`prog_idx`], → NEXT.
  - The end-address test has priority when both conditions are true in the same cycle.
- SETTLE: exactly one cycle with the core still running → CHECK.
- CHECK:
  - sample `dmemout`;
  - if equal to table.expect, `pass_count`+1 (saturates at 255);
  - else set `fail_mask`[`prog_idx`];
  - → NEXT.
- NEXT:
  - `cpu_resetl`=0;
  - if `prog_idx`==NUM_PROGS-1 → DONE, else `prog_idx`+1 → CPU_RST.
- DONE:
  - `done`=1, `busy`=0, `cpu_resetl`=0;
  - results are held until the next accepted `go` or reset.
- Other rules:
  - `go` while `busy` has no effect.
  - `wd_cnt` and `cyc_cnt` clear on every CPU_RST entry.
  - `startpc` holds its last value outside CPU_RST.

Decomposition:
- Shared package prog_seq_pkg holds:
  - the state enum;
  - the program record type {start, end, expect}, each 64 bits;
  - table constants:
    - entry 0 = {0x0, 0x34, 0xF};
    - entry 1 = {0x34, 0x58, 0x123456789ABCDEF0}.
- Sub-module prog_table: combinational index → record lookup from the package constants, so the table can grow without touching the FSM.

Test Plan:
- Behavioural CPU model (PC += 4 per cycle from `startpc`; `dmemout` = scripted value); `go` pulse → program 0 then 1 run. With `dmemout`=0xF then 0x123456789ABCDEF0: `pass_count`=2, `fail_mask`=0, `done`=1, `timeout`=0.
- Program 1 model returns 0xDEAD → `pass_count`=1, `fail_mask`=0x2, `done`=1.
- Model PC stuck at 0x10 in program 0 → after 256 RUN cycles `timeout`=1 and `fail_mask`[0]=1; program 1 still runs and passes → `pass_count`=1.
- Check `cpu_resetl` low for exactly RESET_CYCLES cycles with `startpc`=0x0, then 0x34; `go` pulsed mid-RUN → ignored, sequence unchanged.
- Assert `resetl` low during program 1 RUN → all outputs return to reset values asynchronously; a subsequent `go` reruns both programs cleanly.
- PC reaching end in the same cycle as the watchdog limit → treated as reached; `dmemout` is sampled after SETTLE; no timeout.
